rc4_stream_ctrl: RTL and testbench

RC4_STREAM_CTRL -- requirements
Module: rc4_stream_ctrl

---
 rtl/rc4_stream_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_rc4_stream_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_stream_ctrl.sv
// rtl/rc4_stream_ctrl.sv - RC4 stream cipher controller: key load sequencing and byte encryption
//
// Purpose: loads a 1..16 byte key from an internal 16x8 key buffer into an
// external RC4 keystream generator, waits out its key schedule, then XORs
// each accepted input byte with one keystream byte.
//
// Ports:
//   clk, reset_n                     clock, synchronous active-low reset
//   key_wr, key_addr, key_wdata      key buffer write port (works in every state)
//   start, key_len                   one-cycle load request, key length 1..16
//   busy, keyed, err                 load in progress, keystream ready, sticky bad-length flag
//   din, din_valid, din_ready        plaintext byte input handshake
//   dout, dout_valid, dout_ready     ciphertext byte output handshake
//   rc4_reset_n, rc4_keydata,
//   rc4_enable                       generator control
//   rc4_streamvalue, rc4_ready       generator keystream byte and ready flag
//
// Build option: RC4_STREAM_CTRL_PREFETCH_EN keeps one keystream byte buffered
// so an accepted byte is answered on the next edge.
module rc4_stream_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_wr,
  input  logic [3:0] key_addr,
  input  logic [7:0] key_wdata,
  input  logic       start,
  input  logic [4:0] key_len,
  output logic       busy,
  output logic       keyed,
  output logic       err,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       rc4_reset_n,
  output logic [7:0] rc4_keydata,
  output logic       rc4_enable,
  input  logic [7:0] rc4_streamvalue,
  input  logic       rc4_ready
);

  typedef enum logic [3:0] {
    IDLE, RST, SEND_LEN, SEND_KEY, KSA_WAIT, READY, REQ, WAIT_KS, OUT
  } state_t;

  localparam logic [9:0] KSA_LAST = 10'd771;  // 772 cycles in KSA_WAIT

  state_t     state_q, state_d;
  logic [7:0] key_mem [16];
  logic [4:0] key_len_q;
  logic [3:0] idx_q;
  logic [9:0] ksa_cnt_q;
  logic [7:0] din_q;
  logic [7:0] dout_q;
  logic       dout_valid_q;
  logic       err_q;
  logic       rdy_q;
`ifdef RC4_STREAM_CTRL_PREFETCH_EN
  logic [7:0] ks_q;
  logic       ks_full_q;
`endif

  logic len_ok, start_win, load_req, key_last, din_acc, ks_rise;

  assign len_ok    = (key_len != 5'd0) && (key_len <= 5'd16);
  assign start_win = start && ((state_q == IDLE) || (state_q == READY));
  assign load_req  = start_win && len_ok;
  assign key_last  = ({1'b0, idx_q} == (key_len_q - 5'd1));
  assign din_acc   = din_valid && din_ready;
  // The generator signals a fresh byte by a low-to-high transition of rc4_ready.
  assign ks_rise   = rc4_ready && !rdy_q;

  // Key buffer is deliberately outside reset so keys survive a reset.
  always_ff @(posedge clk) begin
    if (key_wr) key_mem[key_addr] <= key_wdata;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (load_req) state_d = RST;
      RST:      state_d = SEND_LEN;
      SEND_LEN: state_d = SEND_KEY;
      SEND_KEY: if (key_last) state_d = KSA_WAIT;
      KSA_WAIT: if (ksa_cnt_q == KSA_LAST) state_d = READY;
      READY: begin
        if (load_req)       state_d = RST;
`ifdef RC4_STREAM_CTRL_PREFETCH_EN
        else if (!ks_full_q) state_d = REQ;
        else if (din_acc)    state_d = WAIT_KS;
`else
        else if (din_acc)   state_d = REQ;
`endif
      end
      REQ:      state_d = WAIT_KS;
      WAIT_KS: begin
`ifdef RC4_STREAM_CTRL_PREFETCH_EN
        // A full buffer here means a byte was just accepted: answer it now.
        if (ks_full_q)    state_d = OUT;
        else if (ks_rise) state_d = READY;
`else
        if (ks_rise) state_d = OUT;
`endif
      end
      OUT:      if (dout_ready) state_d = READY;
      default:  state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy        = 1'b0;
    keyed       = 1'b0;
    din_ready   = 1'b0;
    rc4_enable  = 1'b0;
    rc4_keydata = 8'h00;
    case (state_q)
      RST:      busy = 1'b1;
      SEND_LEN: begin
        busy        = 1'b1;
        rc4_enable  = 1'b1;
        rc4_keydata = {3'b000, key_len_q};
      end
      SEND_KEY: begin
        busy        = 1'b1;
        rc4_enable  = 1'b1;
        rc4_keydata = key_mem[idx_q];
      end
      KSA_WAIT: busy = 1'b1;
      READY: begin
        keyed = 1'b1;
        // A reload in the same cycle wins; refuse the byte rather than drop it.
`ifdef RC4_STREAM_CTRL_PREFETCH_EN
        din_ready = ks_full_q && !load_req;
`else
        din_ready = !load_req;
`endif
      end
      REQ: begin
        keyed      = 1'b1;
        rc4_enable = 1'b1;
      end
      WAIT_KS:  keyed = 1'b1;
      OUT:      keyed = 1'b1;
      default:  ;
    endcase
  end

  // Datapath and counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_len_q    <= 5'd0;
      idx_q        <= 4'd0;
      ksa_cnt_q    <= 10'd0;
      din_q        <= 8'h00;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdy_q        <= 1'b0;
`ifdef RC4_STREAM_CTRL_PREFETCH_EN
      ks_q         <= 8'h00;
      ks_full_q    <= 1'b0;
`endif
    end else begin
      rdy_q <= rc4_ready;
      if (start_win && !len_ok) err_q <= 1'b1;
      if (load_req) begin
        key_len_q <= key_len;
        idx_q     <= 4'd0;
        ksa_cnt_q <= 10'd0;
`ifdef RC4_STREAM_CTRL_PREFETCH_EN
        ks_full_q <= 1'b0;
`endif
      end
      if (state_q == SEND_KEY) idx_q <= idx_q + 4'd1;
      if (state_q == KSA_WAIT) ksa_cnt_q <= ksa_cnt_q + 10'd1;
      if (din_acc) din_q <= din;
`ifdef RC4_STREAM_CTRL_PREFETCH_EN
      if (state_q == WAIT_KS) begin
        if (ks_full_q) begin
          dout_q       <= din_q ^ ks_q;
          dout_valid_q <= 1'b1;
          ks_full_q    <= 1'b0;
        end else if (ks_rise) begin
          ks_q      <= rc4_streamvalue;
          ks_full_q <= 1'b1;
        end
      end
`else
      if ((state_q == WAIT_KS) && ks_rise) begin
        dout_q       <= din_q ^ rc4_streamvalue;
        dout_valid_q <= 1'b1;
      end
`endif
      if ((state_q == OUT) && dout_ready) dout_valid_q <= 1'b0;
    end
  end

  assign rc4_reset_n = reset_n && (state_q != RST);
  assign err         = err_q;
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;

endmodule

// File: tb/tb_rc4_stream_ctrl.sv
// tb/tb_rc4_stream_ctrl.sv - directed self-checking bench for rc4_stream_ctrl with an RC4 generator model
module tb_rc4_stream_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_wr = 1'b0;
  logic [3:0] key_addr = 4'd0;
  logic [7:0] key_wdata = 8'h00;
  logic       start = 1'b0;
  logic [4:0] key_len = 5'd0;
  logic       busy, keyed, err;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       rc4_reset_n;
  logic [7:0] rc4_keydata;
  logic       rc4_enable;
  logic [7:0] rc4_streamvalue;
  logic       rc4_ready;

  always #5 clk = ~clk;

`ifdef RC4_STREAM_CTRL_PREFETCH_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 6;
`endif

  rc4_stream_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .key_wr(key_wr), .key_addr(key_addr), .key_wdata(key_wdata),
    .start(start), .key_len(key_len),
    .busy(busy), .keyed(keyed), .err(err),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .rc4_reset_n(rc4_reset_n), .rc4_keydata(rc4_keydata), .rc4_enable(rc4_enable),
    .rc4_streamvalue(rc4_streamvalue), .rc4_ready(rc4_ready)
  );

  // RC4 generator model: length byte, key bytes, then one byte per enable,
  // presented 4 edges after the enable edge with a rising rc4_ready.
  logic [7:0] gs [256];
  logic [7:0] gkey [16];
  logic [7:0] gi, gj, gtmp;
  logic [4:0] glen, gcnt;
  int         gphase, gdelay;

  always @(posedge clk) begin
    if (!rc4_reset_n) begin
      gphase = 0; gcnt = 5'd0; gdelay = 0; gi = 8'd0; gj = 8'd0;
      rc4_ready <= 1'b0;
      rc4_streamvalue <= 8'h00;
    end else begin
      if (gdelay > 1) gdelay = gdelay - 1;
      else if (gdelay == 1) begin
        gdelay = 0;
        gi = gi + 8'd1;
        gj = gj + gs[gi];
        gtmp = gs[gi]; gs[gi] = gs[gj]; gs[gj] = gtmp;
        gtmp = gs[gi] + gs[gj];
        rc4_streamvalue <= gs[gtmp];
        rc4_ready <= 1'b1;
      end
      if (rc4_enable) begin
        case (gphase)
          0: begin glen = rc4_keydata[4:0]; gcnt = 5'd0; gphase = 1; end
          1: begin
            gkey[gcnt[3:0]] = rc4_keydata;
            gcnt = gcnt + 5'd1;
            if (gcnt == glen) begin
              for (int k = 0; k < 256; k++) gs[k] = 8'(k);
              gj = 8'd0;
              for (int k = 0; k < 256; k++) begin
                gj = gj + gs[k] + gkey[4'(k % int'(glen))];
                gtmp = gs[k]; gs[k] = gs[gj]; gs[gj] = gtmp;
              end
              gi = 8'd0; gj = 8'd0;
              gphase = 2;
              rc4_ready <= 1'b1;
            end
          end
          default: begin rc4_ready <= 1'b0; gdelay = 4; end
        endcase
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic write_key(input logic [3:0] a, input logic [7:0] d);
    key_wr = 1'b1; key_addr = a; key_wdata = d;
    @(negedge clk);
    key_wr = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] len);
    start = 1'b1; key_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_din_ready(input string tag);
    int n = 0;
    while (!din_ready && n < 200) begin @(negedge clk); n++; end
    check_eq(tag, 32'(din_ready), 32'd1);
  endtask

  task automatic wait_keyed(input string tag);
    int n = 0;
    while (!keyed && n < 2000) begin @(negedge clk); n++; end
    check_eq(tag, 32'(keyed), 32'd1);
  endtask

  // Send one byte, measure edges from acceptance to dout_valid, check dout,
  // optionally hold dout_ready low for hold cycles first.
  task automatic xfer(input string tag, input logic [7:0] d, input logic [7:0] exp, input int hold);
    int n;
    wait_din_ready({tag, "_rdy"});
    din = d; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    n = 0;
    while (!dout_valid && n < 50) begin @(negedge clk); n++; end
    check_eq({tag, "_lat"}, 32'(n), 32'(LAT));
    check_eq({tag, "_dout"}, 32'(dout), 32'(exp));
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check_eq({tag, "_hold"}, {20'd0, dout_valid, din_ready, rc4_enable, 1'b0, dout},
               {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, exp});
    end
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    check_eq({tag, "_clr"}, 32'(dout_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_keyed"}, 32'(keyed), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_dinrdy"}, 32'(din_ready), 32'd0);
    check_eq({tag, "_dout"}, 32'(dout), 32'd0);
    check_eq({tag, "_dvalid"}, 32'(dout_valid), 32'd0);
    check_eq({tag, "_en"}, 32'(rc4_enable), 32'd0);
    check_eq({tag, "_kdata"}, 32'(rc4_keydata), 32'd0);
    check_eq({tag, "_rc4rst"}, 32'(rc4_reset_n), 32'd0);
  endtask

  logic [7:0] pt  [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] ct  [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] ks0 [6] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34};
  logic [7:0] kb  [3] = '{8'h4B, 8'h65, 8'h79};

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) write_key(4'(i), kb[i]);

    // Bad lengths: flag err, stay in IDLE.
    pulse_start(5'd0);
    check_eq("len0_err", 32'(err), 32'd1);
    check_eq("len0_busy", 32'(busy), 32'd0);
    pulse_start(5'd17);
    check_eq("len17_err", 32'(err), 32'd1);
    check_eq("len17_state", {30'd0, busy, keyed}, 32'd0);

    // Valid load, sequence checked cycle by cycle.
    pulse_start(5'd3);
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_rc4rst", 32'(rc4_reset_n), 32'd0);
    check_eq("rst_keyed", 32'(keyed), 32'd0);
    @(negedge clk);
    check_eq("len_en", 32'(rc4_enable), 32'd1);
    check_eq("len_data", 32'(rc4_keydata), 32'h03);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("key_en", 32'(rc4_enable), 32'd1);
      check_eq("key_data", 32'(rc4_keydata), 32'(kb[i]));
    end
    n = 0;
    while (!keyed && n < 2000) begin
      @(negedge clk);
      n++;
      if (!keyed && rc4_enable) check_eq("ksa_en", 32'(rc4_enable), 32'd0);
    end
    check_eq("ksa_len", 32'(n), 32'd773);
    check_eq("ksa_busy", 32'(busy), 32'd0);
    check_eq("err_sticky", 32'(err), 32'd1);

    // Zero plaintext yields the raw keystream; the last byte sees backpressure.
    for (int i = 0; i < 5; i++) xfer("ks", 8'h00, ks0[i], 0);
    xfer("bp", 8'h00, ks0[5], 10);

    // Reload from READY, then encrypt "Plaintext".
    wait_din_ready("reload_rdy");
    pulse_start(5'd3);
    check_eq("reload_busy", 32'(busy), 32'd1);
    wait_keyed("reload_keyed");
    for (int i = 0; i < 9; i++) xfer("pt", pt[i], ct[i], 0);

    // Reset in KSA_WAIT aborts the load.
    wait_din_ready("abort_rdy");
    pulse_start(5'd3);
    repeat (50) @(negedge clk);
    check_eq("abort_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst1");
    reset_n = 1'b1;
    repeat (900) @(negedge clk);
    check_eq("abort_keyed", 32'(keyed), 32'd0);
    check_eq("abort_dvalid", 32'(dout_valid), 32'd0);

    // Key buffer survived reset; start during a load is ignored without err.
    pulse_start(5'd3);
    repeat (50) @(negedge clk);
    pulse_start(5'd0);
    check_eq("busy_start_err", 32'(err), 32'd0);
    wait_keyed("post_rst_keyed");
    xfer("post_rst", 8'h00, 8'hEB, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
